// File: rtl/link_addr_decoder_nch.sv
// rtl/link_addr_decoder_nch.sv - MM master fan-out to NUM_SLV register blocks
// Registers the master request, decodes a select field, and tracks one outstanding read.
module link_addr_decoder_nch #(
  parameter int          NUM_SLV     = 4,
  parameter int          ADDR_W      = 17,
  parameter int          DATA_W      = 64,
  parameter int          SEL_LSB     = 14,
  parameter int          SEL_W       = 3,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] BAD_PATTERN = 32'h5555_AAAA
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         iMM_ADDR,
  input  logic                      iMM_WR_EN,
  input  logic                      iMM_RD_EN,
  input  logic [DATA_W-1:0]         iMM_WR_DATA,
  output logic [DATA_W-1:0]         oMM_RD_DATA,
  output logic                      oMM_RD_DATA_V,
  output logic                      oMM_RD_ERR,
  output logic                      oMM_BUSY,
  output logic [ADDR_W-1:0]         oSLV_ADDR,
  output logic [DATA_W-1:0]         oSLV_WR_DATA,
  output logic [NUM_SLV-1:0]        oSLV_WR_EN,
  output logic [NUM_SLV-1:0]        oSLV_RD_EN,
  input  logic [NUM_SLV*DATA_W-1:0] iSLV_RD_DATA,
  input  logic [NUM_SLV-1:0]        iSLV_RD_DATA_V,
  input  logic                      iCNT_CLR,
  output logic [15:0]               oTIMEOUT_CNT,
  output logic [15:0]               oDROP_CNT
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [SEL_W:0] NUM_SLV_L  = (SEL_W + 1)'(NUM_SLV);
  localparam logic [15:0]    TIMER_LAST = 16'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_laddr;
  logic [ADDR_W-1:0]   r_raddr;
  logic [DATA_W-1:0]   r_lwdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_lwen;
  logic                r_lren;
  logic                r_rd_v;
  logic                r_rd_err;
  logic [SEL_W-1:0]    r_rsel;
  logic [15:0]         r_timer;
  logic [15:0]         r_to_cnt;
  logic [15:0]         r_drop_cnt;

  logic [SEL_W-1:0]    w_sel;
  logic                w_lren_acc;
  logic                w_drop;
  logic                w_active;
  logic [SEL_W-1:0]    w_tsel;
  logic [ADDR_W-1:0]   w_taddr;
  logic [15:0]         w_ttimer;
  logic                w_tmapped;
  logic                w_tvalid;
  logic [DATA_W-1:0]   w_tdata;
  logic [DATA_W-1:0]   w_err_data;
  logic                w_done_ok;
  logic                w_done_unm;
  logic                w_done_to;
  logic                w_done;

  assign w_sel      = r_laddr[SEL_LSB +: SEL_W];
  assign w_lren_acc = r_lren & (r_state == S_IDLE);
  assign w_drop     = r_lren & (r_state == S_WAIT);

  // The accepting cycle already counts as the first wait cycle, so the read
  // target comes straight from the decode until rsel/raddr are latched.
  assign w_active = (r_state == S_WAIT) | w_lren_acc;
  assign w_tsel   = (r_state == S_WAIT) ? r_rsel  : w_sel;
  assign w_taddr  = (r_state == S_WAIT) ? r_raddr : r_laddr;
  assign w_ttimer = (r_state == S_WAIT) ? r_timer : 16'd0;
  assign w_tmapped = ({1'b0, w_tsel} < NUM_SLV_L);

  always_comb begin
    w_tvalid = 1'b0;
    w_tdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_tsel == SEL_W'(i)) begin
        w_tvalid = iSLV_RD_DATA_V[i];
        w_tdata  = iSLV_RD_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_err_data = '0;
    w_err_data[ADDR_W-1:0]     = w_taddr;
    w_err_data[DATA_W-1 -: 32] = BAD_PATTERN;
  end

  assign w_done_ok  = w_active & w_tmapped & w_tvalid;
  assign w_done_unm = w_active & ~w_tmapped;
  assign w_done_to  = w_active & w_tmapped & ~w_tvalid & (w_ttimer == TIMER_LAST);
  assign w_done     = w_done_ok | w_done_unm | w_done_to;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_lren_acc && !w_done) w_state_nxt = S_WAIT;
      S_WAIT: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oSLV_WR_EN = '0;
    oSLV_RD_EN = '0;
    oMM_BUSY   = w_active;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_sel == SEL_W'(i)) begin
        oSLV_WR_EN[i] = r_lwen;
        oSLV_RD_EN[i] = w_lren_acc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_laddr    <= '0;
      r_lwdata   <= '0;
      r_lwen     <= 1'b0;
      r_lren     <= 1'b0;
      r_rsel     <= '0;
      r_raddr    <= '0;
      r_timer    <= '0;
      r_rd_data  <= '0;
      r_rd_v     <= 1'b0;
      r_rd_err   <= 1'b0;
      r_to_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_laddr  <= iMM_ADDR;
      r_lwdata <= iMM_WR_DATA;
      r_lwen   <= iMM_WR_EN;
      r_lren   <= iMM_RD_EN;
      if (w_lren_acc) begin
        r_rsel  <= w_sel;
        r_raddr <= r_laddr;
      end
      if (w_active && !w_done) begin
        r_timer <= w_ttimer + 16'd1;
      end else begin
        r_timer <= 16'd0;
      end
      r_rd_v   <= w_done;
      r_rd_err <= w_done_unm | w_done_to;
      if (w_done_ok) begin
        r_rd_data <= w_tdata;
      end else if (w_done_unm || w_done_to) begin
        r_rd_data <= w_err_data;
      end
      if (iCNT_CLR) begin
        r_to_cnt   <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_done_to && r_to_cnt != 16'hFFFF) r_to_cnt <= r_to_cnt + 16'd1;
        if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign oMM_RD_DATA   = r_rd_data;
  assign oMM_RD_DATA_V = r_rd_v;
  assign oMM_RD_ERR    = r_rd_err;
  assign oSLV_ADDR     = r_laddr;
  assign oSLV_WR_DATA  = r_lwdata;
  assign oTIMEOUT_CNT  = r_to_cnt;
  assign oDROP_CNT     = r_drop_cnt;

endmodule
